// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Serial-to-parallel frame receiver. WIDTH serial bits are assembled into a
// word under a bit-valid strobe. Each completed word goes to a downstream
// consumer through a one-entry holding register. The sticky OVR flag records
// every dropped bit and every discarded word.
//
// Ports
//   CP        clock; all state changes on the rising edge
//   MR        synchronous active-low reset
//   SIN       serial data bit
//   SEN       SIN is valid this cycle
//   SYNC      frame start; restarts the bit counter
//   DIR       0 = MSB-first, 1 = LSB-first; sampled for each bit
//   DOUT      word in the holding register
//   DVALID    DOUT holds an unconsumed word
//   DREADY    consumer accepts DOUT when DVALID & DREADY
//   OVR       sticky overrun / frame-discard flag
//   OVR_CLR   clears OVR; a set in the same cycle wins
//   BUSY      a frame is partially or fully held in the shift register
//   state_dbg current FSM state (IDLE=0, SHIFT=1, STALL=2)
//
// Handshake: DOUT transfers on a rising edge where DVALID and DREADY are both
// high. DOUT does not change while DVALID is high until that transfer happens.
// DREADY may stay high while DVALID is low; it has no effect then.
module serial_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             SYNC,
  input  logic             DIR,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             OVR,
  input  logic             OVR_CLR,
  output logic             BUSY,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               ovr_q, ovr_d;

  logic               pop;
  logic               ovr_set;
  logic [WIDTH-1:0]   first_word;
  logic [WIDTH-1:0]   shifted_word;

  assign pop = dvalid_q & DREADY;

  // Bit 0 of a new frame goes into a cleared register. Then no stale bits
  // can survive if DIR changes partway through a frame.
  assign first_word   = DIR ? {SIN, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, SIN};
  assign shifted_word = DIR ? {SIN, sr_q[WIDTH-1:1]}   : {sr_q[WIDTH-2:0], SIN};

  always_ff @(posedge CP) begin
    if (!MR) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_set  = 1'b0;

    // A pop frees the holding register. A reload in the branches below
    // overrides this in the same cycle.
    if (pop) dvalid_d = 1'b0;

    if (SYNC) begin
      // A SYNC in IDLE costs no data. In SHIFT or STALL it throws away
      // the bits already collected.
      if (state_q != IDLE) ovr_set = 1'b1;
      if (SEN) begin
        sr_d    = first_word;
        cnt_d   = CNT_W'(1);
        state_d = SHIFT;
      end else begin
        sr_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (SEN) begin
            sr_d    = first_word;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (SEN) begin
            sr_d = shifted_word;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d = '0;
              if (!dvalid_q || pop) begin
                dout_d   = shifted_word;
                dvalid_d = 1'b1;
                state_d  = IDLE;
              end else begin
                state_d  = STALL;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        STALL: begin
          if (pop) begin
            dout_d   = sr_q;
            dvalid_d = 1'b1;
            if (SEN) begin
              sr_d    = first_word;
              cnt_d   = CNT_W'(1);
              state_d = SHIFT;
            end else begin
              sr_d    = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else if (SEN) begin
            // The shift register is full and cannot drain, so the bit is dropped.
            ovr_set = 1'b1;
          end
        end
        default: begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    // A new overrun event takes priority over a clear in the same cycle.
    ovr_d = ovr_set | (ovr_q & ~OVR_CLR);
  end

  assign DOUT      = dout_q;
  assign DVALID    = dvalid_q;
  assign OVR       = ovr_q;
  assign BUSY      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int W = 4;

  logic         CP = 1'b0;
  logic         MR = 1'b0;
  logic         SIN = 1'b0;
  logic         SEN = 1'b0;
  logic         SYNC = 1'b0;
  logic         DIR = 1'b0;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         DREADY = 1'b0;
  logic         OVR;
  logic         OVR_CLR = 1'b0;
  logic         BUSY;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  serial_frame_rx #(.WIDTH(W)) dut (
    .CP(CP), .MR(MR), .SIN(SIN), .SEN(SEN), .SYNC(SYNC), .DIR(DIR),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .OVR(OVR),
    .OVR_CLR(OVR_CLR), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 CP = ~CP;

  // Driver tasks: inputs change 1 time unit after a rising edge, and outputs
  // are sampled at the same point. Each sample shows the result of the edge
  // just before it.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic send_bit(input logic b);
    SEN = 1'b1;
    SIN = b;
    tick();
    SEN = 1'b0;
  endtask

  task automatic idle_cycle();
    SEN = 1'b0;
    tick();
  endtask

  // Sends a word in transmission order: MSB first when DIR=0, LSB first
  // when DIR=1.
  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      if (DIR == 1'b0) send_bit(w[W-1-i]);
      else             send_bit(w[i]);
    end
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] stream_words [8];
  int           pulses;

  initial begin
    stream_words[0] = 4'h3; stream_words[1] = 4'hC;
    stream_words[2] = 4'h7; stream_words[3] = 4'hE;
    stream_words[4] = 4'h1; stream_words[5] = 4'h8;
    stream_words[6] = 4'hF; stream_words[7] = 4'h6;

    // Reset behaviour
    MR = 1'b0;
    tick(); tick();
    check("rst_dout",   16'(DOUT),   16'h0);
    check("rst_dvalid", 16'(DVALID), 16'h0);
    MR = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy", 16'(BUSY), 16'h1);
    SEN = 1'b1; SIN = 1'b1; MR = 1'b0;
    tick();
    MR = 1'b1; SEN = 1'b0;
    check("mr_dout",   16'(DOUT),   16'h0);
    check("mr_dvalid", 16'(DVALID), 16'h0);
    check("mr_ovr",    16'(OVR),    16'h0);
    check("mr_busy",   16'(BUSY),   16'h0);

    // Clean frames after reset: MSB-first, then LSB-first
    DREADY = 1'b1; DIR = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("msb_noval", 16'(DVALID), 16'h0);
    send_bit(1'b1);
    check("msb_dout",   16'(DOUT),   16'hB);
    check("msb_dvalid", 16'(DVALID), 16'h1);
    check("msb_busy",   16'(BUSY),   16'h0);
    idle_cycle();
    check("msb_popped", 16'(DVALID), 16'h0);

    DIR = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("lsb_dout",   16'(DOUT),   16'hD);
    check("lsb_dvalid", 16'(DVALID), 16'h1);
    idle_cycle();

    // Stall, overrun, and recovery
    DIR = 1'b0; DREADY = 1'b0;
    send_word(4'hA);
    check("stall_first", 16'(DOUT), 16'hA);
    send_word(4'h5);
    check("stall_dvalid", 16'(DVALID),    16'h1);
    check("stall_dout",   16'(DOUT),      16'hA);
    check("stall_busy",   16'(BUSY),      16'h1);
    check("stall_state",  16'(state_dbg), 16'h2);
    check("stall_ovr0",   16'(OVR),       16'h0);
    // Extra bit while stalled. OVR_CLR is high in the same cycle, and the
    // set must still win.
    OVR_CLR = 1'b1;
    send_bit(1'b1);
    OVR_CLR = 1'b0;
    check("ovr_set",      16'(OVR),  16'h1);
    check("ovr_dout_hold", 16'(DOUT), 16'hA);
    OVR_CLR = 1'b1;
    idle_cycle();
    OVR_CLR = 1'b0;
    check("ovr_clr", 16'(OVR), 16'h0);
    DREADY = 1'b1;
    idle_cycle();
    check("recov_dout",   16'(DOUT),   16'h5);
    check("recov_dvalid", 16'(DVALID), 16'h1);
    check("recov_busy",   16'(BUSY),   16'h0);
    idle_cycle();
    check("recov_pop", 16'(DVALID), 16'h0);

    // SYNC in the middle of a frame
    send_bit(1'b1); send_bit(1'b1);
    SYNC = 1'b1;
    send_bit(1'b0);
    SYNC = 1'b0;
    check("sync_ovr",  16'(OVR),  16'h1);
    check("sync_busy", 16'(BUSY), 16'h1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("sync_dout",   16'(DOUT),   16'h7);
    check("sync_dvalid", 16'(DVALID), 16'h1);
    OVR_CLR = 1'b1;
    idle_cycle();
    OVR_CLR = 1'b0;
    // SYNC while IDLE must not set OVR.
    SYNC = 1'b1;
    idle_cycle();
    SYNC = 1'b0;
    check("sync_idle_ovr",  16'(OVR),  16'h0);
    check("sync_idle_busy", 16'(BUSY), 16'h0);

    // Back-to-back streaming with DREADY held high
    DIR = 1'b0; DREADY = 1'b1; pulses = 0;
    for (int f = 0; f < 8; f++) exp_q.push_back(stream_words[f]);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < W; i++) begin
        send_bit(stream_words[f][W-1-i]);
        check("strm_dvalid", 16'(DVALID), (i == W-1) ? 16'h1 : 16'h0);
        if (DVALID) begin
          pulses++;
          if (exp_q.size() > 0) check("strm_word", 16'(DOUT), 16'(exp_q.pop_front()));
        end
      end
    end
    idle_cycle();
    check("strm_pulses", 16'(pulses),       16'd8);
    check("strm_left",   16'(exp_q.size()), 16'd0);
    check("strm_ovr",    16'(OVR),          16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
